mem_stage: RTL
==============

Name: mem_stage

Overview:
Memory-access stage of the 5-stage MIPS pipeline, directly downstream of EX. It consumes the EX/MEM pipeline register (ALU result, store data, destination register, M and WB control) and drives a single-port data-memory request/acknowledge interface. It stalls the pipeline while an access is outstanding and produces the MEM/WB pipeline register plus the branch-taken signal.

Parameters:
TIMEOUT, 16, max WAIT cycles before an access is aborted with bus_err (≥2)
CNT_W, 5, width of the wait counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
res  in  32  ALU result from EX (address / ALU value)
write_data_ex  in  32  store data from EX
write_register_ex  in  5  destination register from EX
zero  in  1  ALU zero flag from EX
m_MEM  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
wb_MEM  in  2  [1]=reg_write, [0]=mem_to_reg
dmem_req  out  1  memory request
dmem_we  out  1  1=write, 0=read
dmem_addr  out  32  byte address
dmem_wdata  out  32  write data
dmem_ack  in  1  access complete this cycle
dmem_rdata  in  32  read data, valid when dmem_ack=1
stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
pc_src  out  1  branch taken
bus_err  out  1  one-cycle pulse on timeout (or misalignment)
wb_WB  out  2  registered WB control
rd_WB  out  5  registered destination register
read_data_wb  out  32  registered load data
alu_res_wb  out  32  registered ALU result

Behaviour:
- Clock/reset: one clock clk; reset rst synchronous, active-high.
- mem_op = m_MEM[1] | m_MEM[0]; both set simultaneously is treated as write.
- FSM states: IDLE, WAIT.
  - IDLE: mem_op=0 -> stay IDLE. mem_op=1 and dmem_ack=1 -> stay IDLE (zero-wait). mem_op=1 and dmem_ack=0 -> WAIT, counter cleared to 0.
  - WAIT: dmem_ack=1 -> IDLE. Counter reaching TIMEOUT-1 without ack -> IDLE, bus_err pulse. Otherwise counter+1.
- dmem_req = (IDLE & mem_op) | WAIT. Combinational, same cycle as inputs.
- dmem_we = m_MEM[0]; dmem_addr = res; dmem_wdata = write_data_ex. These are held stable because upstream is frozen by stall_mem.
- stall_mem = dmem_req & ~dmem_ack & ~timeout_hit. It is combinational and deasserts in the completing cycle.
- pc_src = m_MEM[2] & zero, combinational. It is forced to 0 while stall_mem=1.
- MEM/WB register (posedge clk):
  - stall_mem=1 -> load bubble (wb_WB=0, rd_WB=0, data fields unchanged).
  - Otherwise load wb_WB=wb_MEM, rd_WB=write_register_ex, alu_res_wb=res, read_data_wb=dmem_rdata if read acked, else 0.
  - On timeout abort: wb_WB forced to 0 (load suppressed, no register write).
- Latency: zero-wait access has 1 cycle from EX/MEM inputs to MEM/WB outputs; N-wait access has N+1 cycles.
- Reset (any state, including mid-WAIT): state=IDLE, counter=0, all MEM/WB outputs 0, bus_err=0. dmem_req follows inputs from the next cycle. An aborted access is not retried.
- dmem_ack while dmem_req=0 is ignored.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: a mem_op with res[1:0]≠0 issues no dmem_req, produces no stall, and pulses bus_err for 1 cycle. It writes a bubble (wb_WB=0) into MEM/WB.
- Undefined: no check; the address is passed through unmodified.

Test Plan:
- Zero-wait load: m_MEM=010, wb_MEM=11, res=0x40, rd=5, ack same cycle, rdata=0xDEADBEEF -> no stall. Next edge: wb_WB=11, rd_WB=5, read_data_wb=0xDEADBEEF.
- 3-wait store: m_MEM=001, res=0x80, wdata=0x1234, ack on 4th cycle -> stall_mem high 3 cycles, dmem_we=1, addr/wdata stable, 3 bubbles (wb_WB=0) into WB, then wb_WB=wb_MEM.
- Timeout: read, ack never, TIMEOUT=16 -> stall for 15 cycles, bus_err pulse in the 16th, wb_WB=0 after, state IDLE.
- Branch: m_MEM=100, zero=1 -> pc_src=1 same cycle. With zero=0 -> pc_src=0.
- Reset mid-WAIT: rst asserted on 2nd wait cycle -> next edge all outputs 0, state IDLE. After release, a fresh read with immediate ack completes normally.
- MEM_ALIGN_CHECK_EN: load at res=0x42 -> dmem_req=0, bus_err pulse, wb_WB=0. Without the macro: dmem_addr=0x42 and a normal access.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory request/ack handshake with wait-state timeout and the MEM/WB register.
// Optional `define MEM_ALIGN_CHECK_EN rejects word accesses whose address has nonzero res[1:0].
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register_ex,
    input  logic        zero,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        pc_src,
    output logic        bus_err,
    output logic [1:0]  wb_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             mem_op, misalign, timeout_hit, rd_ack;

    assign mem_op = m_MEM[1] | m_MEM[0];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (state == IDLE) & mem_op & (res[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign dmem_req   = ((state == IDLE) & mem_op & ~misalign) | (state == WAIT);
    assign dmem_we    = m_MEM[0];
    assign dmem_addr  = res;
    assign dmem_wdata = write_data_ex;

    // The request cycle in IDLE counts as the first stalled cycle, so WAIT
    // gives up when the count would reach TIMEOUT-1 (TIMEOUT-1 stalls total).
    assign timeout_hit = (state == WAIT) & ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 2));
    assign stall_mem   = dmem_req & ~dmem_ack & ~timeout_hit;
    assign pc_src      = m_MEM[2] & zero & ~stall_mem;
    assign bus_err     = timeout_hit | misalign;
    assign rd_ack      = dmem_req & dmem_ack & m_MEM[1] & ~m_MEM[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_req & ~dmem_ack) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ack | timeout_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Aborted or rejected accesses still retire, but with write-back suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_WB        <= '0;
            rd_WB        <= '0;
            read_data_wb <= '0;
            alu_res_wb   <= '0;
        end else if (stall_mem) begin
            wb_WB <= '0;
            rd_WB <= '0;
        end else begin
            wb_WB        <= bus_err ? 2'b00 : wb_MEM;
            rd_WB        <= write_register_ex;
            alu_res_wb   <= res;
            read_data_wb <= rd_ack ? dmem_rdata : 32'h0;
        end
    end
endmodule
